// File: rtl/cell_plot_scheduler.sv
// rtl/cell_plot_scheduler.sv - round-robin cell painter for vga_adapter; optional full-grid clear via CLEAR_ALL_EN
module cell_plot_scheduler #(
    parameter int         GRID_SIZE     = 28,
    parameter int         PIXEL_SIZE    = 4,
    parameter int         GRID_OFFSET_X = 10,
    parameter int         GRID_OFFSET_Y = 4,
    parameter logic [2:0] CLEAR_COLOUR  = 3'b111
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [4:0] req0_cx,
    input  logic [4:0] req0_cy,
    input  logic [2:0] req0_colour,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [4:0] req1_cx,
    input  logic [4:0] req1_cy,
    input  logic [2:0] req1_colour,
    input  logic       clear_i,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       drop_o,
    output logic       clear_done_o
);

    localparam int SW = $clog2(PIXEL_SIZE);
    localparam logic [SW-1:0] PMAX = SW'(PIXEL_SIZE - 1);
    localparam logic [4:0]    CMAX = 5'(GRID_SIZE - 1);

    typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;

    state_t        state, state_n;
    logic [4:0]    cx, cy;
    logic [SW-1:0] sx, sy;
    logic          last_grant;
    logic          clear_pend;
    logic          grant0, grant1, accept, in_range;
    logic [4:0]    a_cx, a_cy;
    logic [2:0]    a_colour;
    logic          pix_last, sweep_last;
    logic [SW-1:0] nsx, nsy;
    logic [4:0]    ncx, ncy;

    // Screen coordinate of pixel (s) inside cell (c); wraps to the adapter's bus widths.
    function automatic logic [7:0] pos_x(input logic [4:0] c, input logic [SW-1:0] s);
        return 8'(GRID_OFFSET_X) + 8'(c) * 8'(PIXEL_SIZE) + 8'(s);
    endfunction

    function automatic logic [6:0] pos_y(input logic [4:0] c, input logic [SW-1:0] s);
        return 7'(GRID_OFFSET_Y) + 7'(c) * 7'(PIXEL_SIZE) + 7'(s);
    endfunction

    // Round-robin grant; a pending clear blocks both requesters, reset forces ready low.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_grant);
        grant1     = req1_valid & (~req0_valid | ~last_grant);
        req0_ready = resetn & (state == IDLE) & grant0 & ~clear_pend;
        req1_ready = resetn & (state == IDLE) & grant1 & ~clear_pend;
        accept     = req0_ready | req1_ready;
        a_cx       = req1_ready ? req1_cx     : req0_cx;
        a_cy       = req1_ready ? req1_cy     : req0_cy;
        a_colour   = req1_ready ? req1_colour : req0_colour;
        in_range   = ({1'b0, a_cx} < 6'(GRID_SIZE)) && ({1'b0, a_cy} < 6'(GRID_SIZE));
    end

    // Counter stepping: row-major inside a cell, and cell-to-cell only while sweeping.
    always_comb begin
        pix_last   = (sx == PMAX) && (sy == PMAX);
        sweep_last = pix_last && (cx == CMAX) && (cy == CMAX);
        nsx        = sx + SW'(1);
        nsy        = (sx == PMAX) ? sy + SW'(1) : sy;
        ncx        = cx;
        ncy        = cy;
        if (state == CLEAR && pix_last) begin
            ncx = (cx == CMAX) ? 5'd0 : cx + 5'd1;
            ncy = (cx == CMAX) ? cy + 5'd1 : cy;
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (clear_pend)             state_n = CLEAR;
                else if (accept && in_range) state_n = PAINT;
            end
            PAINT:   if (pix_last)   state_n = IDLE;
            CLEAR:   if (sweep_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: latch requests, walk the burst, register the adapter write port.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cx         <= '0;
            cy         <= '0;
            sx         <= '0;
            sy         <= '0;
            last_grant <= 1'b1;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            drop_o     <= 1'b0;
        end else begin
            drop_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_pend) begin
                        cx         <= '0;
                        cy         <= '0;
                        sx         <= '0;
                        sy         <= '0;
                        vga_x      <= pos_x(5'd0, '0);
                        vga_y      <= pos_y(5'd0, '0);
                        vga_colour <= CLEAR_COLOUR;
                        vga_plot   <= 1'b1;
                    end else if (accept) begin
                        cx         <= a_cx;
                        cy         <= a_cy;
                        last_grant <= req1_ready;
                        if (in_range) begin
                            sx         <= '0;
                            sy         <= '0;
                            vga_x      <= pos_x(a_cx, '0);
                            vga_y      <= pos_y(a_cy, '0);
                            vga_colour <= a_colour;
                            vga_plot   <= 1'b1;
                        end else begin
                            drop_o <= 1'b1;
                        end
                    end
                end
                PAINT, CLEAR: begin
                    if (state_n == IDLE) begin
                        vga_plot <= 1'b0;
                    end else begin
                        sx    <= nsx;
                        sy    <= nsy;
                        cx    <= ncx;
                        cy    <= ncy;
                        vga_x <= pos_x(ncx, nsx);
                        vga_y <= pos_y(ncy, nsy);
                    end
                end
                default: vga_plot <= 1'b0;
            endcase
        end
    end

    assign busy = (state != IDLE);

`ifdef CLEAR_ALL_EN
    // A clear pulse always re-arms, even while a sweep is running.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)                          clear_pend <= 1'b0;
        else if (clear_i)                     clear_pend <= 1'b1;
        else if (state == IDLE && clear_pend) clear_pend <= 1'b0;
    end

    assign clear_done_o = (state == CLEAR) && sweep_last;
`else
    logic unused_clear;
    assign unused_clear = clear_i;
    assign clear_pend   = 1'b0;
    assign clear_done_o = 1'b0;
`endif

endmodule

// File: tb/tb_cell_plot_scheduler.sv
// tb/tb_cell_plot_scheduler.sv - scoreboard bench for cell_plot_scheduler (CLEAR_ALL_EN selects the sweep test)
module tb_cell_plot_scheduler;

    localparam int GS = 28;
    localparam int PS = 4;
    localparam int OX = 10;
    localparam int OY = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0] req0_cx, req0_cy, req1_cx, req1_cy;
    logic [2:0] req0_colour, req1_colour;
    logic       clear_i;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, busy, drop_o, clear_done_o;

    cell_plot_scheduler dut (
        .CLOCK_50(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cx(req0_cx),
        .req0_cy(req0_cy), .req0_colour(req0_colour),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cx(req1_cx),
        .req1_cy(req1_cy), .req1_colour(req1_colour),
        .clear_i(clear_i), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .drop_o(drop_o), .clear_done_o(clear_done_o)
    );

    always #5 clk = ~clk;

    typedef struct { bit drop; bit clr; bit last; logic [7:0] x; logic [6:0] y; logic [2:0] c; } exp_t;
    typedef struct { logic [4:0] cx; logic [4:0] cy; logic [2:0] c; } req_t;

    exp_t expq[$];
    req_t q0[$], q1[$];
    int   checks = 0;
    int   fails  = 0;
    bit   m_last = 1'b1;
    bit   gap_check = 1'b0;
    bit   seen_burst = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: an accepted cell becomes PS*PS row-major pixels, or one drop.
    task automatic push_req(input req_t r);
        exp_t e;
        int   v;
        e = '{default: 0};
        if (int'(r.cx) >= GS || int'(r.cy) >= GS) begin
            e.drop = 1'b1;
            expq.push_back(e);
        end else begin
            for (int py = 0; py < PS; py++)
                for (int px = 0; px < PS; px++) begin
                    v = OX + int'(r.cx) * PS + px; e.x = v[7:0];
                    v = OY + int'(r.cy) * PS + py; e.y = v[6:0];
                    e.c = r.c;
                    expq.push_back(e);
                end
        end
    endtask

    task automatic push_clear();
        exp_t e;
        int   v;
        e = '{default: 0};
        for (int gy = 0; gy < GS; gy++)
            for (int gx = 0; gx < GS; gx++)
                for (int py = 0; py < PS; py++)
                    for (int px = 0; px < PS; px++) begin
                        v = OX + gx * PS + px; e.x = v[7:0];
                        v = OY + gy * PS + py; e.y = v[6:0];
                        e.c = 3'b111;
                        e.clr = 1'b1;
                        e.last = (gx == GS-1) && (gy == GS-1) && (px == PS-1) && (py == PS-1);
                        expq.push_back(e);
                    end
    endtask

    // Service order for two continuously held queues: alternate while both wait, then drain the rest.
    task automatic model_batch();
        int i0 = 0;
        int i1 = 0;
        int pick;
        while (i0 < q0.size() || i1 < q1.size()) begin
            if (i0 < q0.size() && i1 < q1.size()) pick = m_last ? 0 : 1;
            else                                 pick = (i0 < q0.size()) ? 0 : 1;
            if (pick == 1) begin push_req(q1[i1]); i1++; end
            else           begin push_req(q0[i0]); i0++; end
            m_last = (pick == 1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || busy) && n < 15000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain_empty", expq.size(), 0);
    endtask

    task automatic run_batch(input bit do_model, input bit gap, input int pulse_at);
        bit acc0 = 1'b0;
        bit acc1 = 1'b0;
        int cyc = 0;
        if (do_model) model_batch();
        gap_check  = gap;
        seen_burst = 1'b0;
        while ((q0.size() > 0 || q1.size() > 0) && cyc < 15000) begin
            @(negedge clk);
            if (acc0) void'(q0.pop_front());
            if (acc1) void'(q1.pop_front());
            clear_i    = (cyc == pulse_at);
            req0_valid = (q0.size() > 0);
            req1_valid = (q1.size() > 0);
            if (req0_valid) begin req0_cx = q0[0].cx; req0_cy = q0[0].cy; req0_colour = q0[0].c; end
            if (req1_valid) begin req1_cx = q1[0].cx; req1_cy = q1[0].cy; req1_colour = q1[0].c; end
            #1;
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            cyc++;
        end
        if (cyc >= 15000) chk("batch_timeout", 1, 0);
        clear_i = 1'b0;
        drain();
        gap_check = 1'b0;
    endtask

    task automatic single_req(input bit port, input logic [4:0] cx, input logic [4:0] cy, input logic [2:0] c);
        req_t r;
        r.cx = cx; r.cy = cy; r.c = c;
        push_req(r);
        m_last = port;
        @(negedge clk);
        if (port) begin req1_valid = 1; req1_cx = cx; req1_cy = cy; req1_colour = c; end
        else      begin req0_valid = 1; req0_cx = cx; req0_cy = cy; req0_colour = c; end
        #1 chk("single_ready", port ? req1_ready : req0_ready, 1);
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 0;
    endtask

    function automatic req_t rnd_req();
        req_t r;
        r.cx = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, GS-1)) : 5'($urandom_range(GS, 31));
        r.cy = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, GS-1)) : 5'($urandom_range(GS, 31));
        r.c  = 3'($urandom_range(0, 7));
        return r;
    endfunction

    // Monitor: pops one expectation per plotted pixel or drop pulse.
    initial begin
        exp_t e;
        bit   prev_plot = 0;
        bit   run_clr = 0;
        int   run = 0;
        int   idle_run = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_plot  = 0;
                seen_burst = 0;
            end else begin
                chk("busy_matches_plot", busy, vga_plot);
                if (vga_plot) begin
                    if (!prev_plot) begin
                        run = 0;
                        if (gap_check && seen_burst) chk("idle_gap", idle_run, 1);
                    end
                    run++;
                    if (expq.size() == 0) begin
                        chk("unexpected_plot", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        if (run == 1) run_clr = e.clr;
                        chk("plot_not_drop", e.drop, 0);
                        chk("vga_x", vga_x, e.x);
                        chk("vga_y", vga_y, e.y);
                        chk("vga_colour", vga_colour, e.c);
                        chk("clear_done", clear_done_o, e.last);
                        if (e.clr) chk("ready_in_clear", {req0_ready, req1_ready}, 0);
                    end
                end else begin
                    if (prev_plot) begin
                        chk("burst_len", run, run_clr ? GS*GS*PS*PS : PS*PS);
                        seen_burst = 1;
                        idle_run = 0;
                    end
                    idle_run++;
                    chk("clear_done_idle", clear_done_o, 0);
                end
                if (drop_o) begin
                    if (expq.size() == 0) chk("unexpected_drop", 1, 0);
                    else begin
                        e = expq.pop_front();
                        chk("drop_expected", e.drop, 1);
                    end
                end
                prev_plot = vga_plot;
            end
        end
    end

    initial begin
        req_t r;
        resetn = 0; clear_i = 0;
        req0_valid = 1; req0_cx = 0; req0_cy = 0; req0_colour = 0;
        req1_valid = 0; req1_cx = 0; req1_cy = 0; req1_colour = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_plot", vga_plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_xyc", {vga_x, vga_y, vga_colour}, 0);
        chk("rst_drop_done", {drop_o, clear_done_o}, 0);
        chk("rst_ready", req0_ready, 0);
        req0_valid = 0;
        @(negedge clk) resetn = 1;

        // Both held from reset: req0, req1, req0 with one idle cycle between bursts
        r.cx = 1; r.cy = 2; r.c = 3'b001; q0.push_back(r);
        r.cx = 3; r.cy = 4; r.c = 3'b010; q0.push_back(r);
        r.cx = 5; r.cy = 6; r.c = 3'b100; q1.push_back(r);
        run_batch(1, 1, -1);

        // Lone req0 at cell (0,0)
        single_req(0, 5'd0, 5'd0, 3'b000);
        drain();

        // Far corner then out-of-range on req1
        r.cx = 27; r.cy = 27; r.c = 3'b110; q1.push_back(r);
        r.cx = 28; r.cy = 3;  r.c = 3'b011; q1.push_back(r);
        run_batch(1, 0, -1);

        // Random batches
        for (int b = 0; b < 6; b++) begin
            int n0 = $urandom_range(0, 3);
            int n1 = $urandom_range(0, 3);
            for (int i = 0; i < n0; i++) q0.push_back(rnd_req());
            for (int i = 0; i < n1; i++) q1.push_back(rnd_req());
            run_batch(1, 0, -1);
        end

`ifdef CLEAR_ALL_EN
        // Clear during a burst: burst completes, full sweep, then the waiting request
        r.cx = 7; r.cy = 8; r.c = 3'b010; q0.push_back(r); push_req(r);
        push_clear();
        r.cx = 9; r.cy = 1; r.c = 3'b101; q0.push_back(r); push_req(r);
        m_last = 0;
        run_batch(0, 0, 4);
`else
        // Clear pulse is ignored without the sweep feature
        r.cx = 10; r.cy = 10; r.c = 3'b101; q0.push_back(r);
        run_batch(1, 0, 0);
`endif

        // Reset during the 8th plot of a burst
        single_req(0, 5'd2, 5'd3, 3'b101);
        repeat (7) @(negedge clk);
        #1 resetn = 0;
        #1;
        chk("arst_plot", vga_plot, 0);
        chk("arst_busy", busy, 0);
        chk("arst_x", vga_x, 0);
        expq.delete();
        m_last = 1;
        repeat (2) @(negedge clk);
        resetn = 1;

        // After reset req0 wins the tie again
        r.cx = 11; r.cy = 12; r.c = 3'b011; q0.push_back(r);
        r.cx = 13; r.cy = 14; r.c = 3'b110; q1.push_back(r);
        run_batch(1, 1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
